// File: rtl/serial_accumulate_ctrl_pkg.sv
// Shared definitions for the serial accumulate controller.
// State encoding and default datapath width.
package serial_accumulate_ctrl_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_ADD     = 2'd1,
        ST_SEND    = 2'd2
    } state_t;

endpackage

// File: rtl/serial_accumulate_ctrl_piso.sv
// Parallel-load, shift-right-on-enable register.
// Serial output is the LSB; zeros fill from the top.
module shift_reg_piso #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] data;

    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else if (load) begin
            data <= din;
        end else if (shift) begin
            data <= data >> 1;
        end
    end

    assign sout = data[0];

endmodule

// File: rtl/serial_accumulate_ctrl.sv
// Sequencer for the serial accumulate datapath:
// SIPO in, external adder, accumulator, PISO out.
module serial_accumulate_ctrl
    import serial_accumulate_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             acc_clear,
    output logic [WIDTH-1:0] sipo_input,
    output logic [WIDTH-1:0] register_input,
    input  logic [WIDTH-1:0] piso_output,
    output logic             ser_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    out_cnt;
    logic [WIDTH-1:0] sipo;
    logic [WIDTH-1:0] acc;
    logic             piso_load;
    logic             piso_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_COLLECT;
            bit_cnt   <= '0;
            out_cnt   <= '0;
            sipo      <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                ST_COLLECT: begin
                    if (acc_clear) begin
                        acc <= '0;
                    end
                    if (in_valid) begin
                        sipo[bit_cnt] <= ser_in;
                        if (bit_cnt == LAST) begin
                            bit_cnt  <= '0;
                            state    <= ST_ADD;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                ST_ADD: begin
                    // Sum wraps at WIDTH bits; the adder has no carry-out.
                    acc       <= piso_output;
                    out_cnt   <= '0;
                    state     <= ST_SEND;
                    out_valid <= 1'b1;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (out_cnt == LAST) begin
                            out_cnt   <= '0;
                            state     <= ST_COLLECT;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            out_cnt <= out_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state     <= ST_COLLECT;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign piso_load  = (state == ST_ADD);
    assign piso_shift = (state == ST_SEND) && out_ready;

    shift_reg_piso #(
        .WIDTH(WIDTH)
    ) u_piso (
        .clk  (clk),
        .reset(reset),
        .load (piso_load),
        .shift(piso_shift),
        .din  (piso_output),
        .sout (ser_out)
    );

    assign sipo_input     = sipo;
    assign register_input = acc;

endmodule

// File: tb/tb_serial_accumulate_ctrl.sv
// Directed bench for serial_accumulate_ctrl with a behavioural adder.
module tb_serial_accumulate_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ser_in = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       acc_clear = 1'b0;
    logic [3:0] sipo_input;
    logic [3:0] register_input;
    logic [3:0] piso_output;
    logic       ser_out;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int xfers = 0;

    always #5 clk = ~clk;

    // External 4-bit adder, carry discarded
    assign piso_output = sipo_input + register_input;

    serial_accumulate_ctrl #(.WIDTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .ser_in        (ser_in),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .acc_clear     (acc_clear),
        .sipo_input    (sipo_input),
        .register_input(register_input),
        .piso_output   (piso_output),
        .ser_out       (ser_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy)
    );

    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) xfers <= xfers + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic collect(input logic [3:0] op, input bit gap, input int clr_idx);
        for (int i = 0; i < 4; i++) begin
            if (gap) begin
                in_valid  = 1'b0;
                acc_clear = 1'b0;
                ser_in    = ~op[i];
                @(negedge clk);
            end
            ser_in    = op[i];
            in_valid  = 1'b1;
            acc_clear = (i == clr_idx);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        acc_clear = 1'b0;
        ser_in    = 1'b0;
    endtask

    task automatic recv(input logic [3:0] exp, input int stall_at,
                        input int stall_len, output logic [3:0] got);
        int n  = 0;
        int st = 0;
        int first = -1;
        bit ir_bad = 0;
        got = '0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (n == stall_at && st < stall_len && out_valid) begin
                out_ready = 1'b0;
                st++;
                check("stall_valid", int'(out_valid), 1);
                check("stall_ser_out", int'(ser_out), int'(exp[n]));
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid) begin
                if (first < 0) first = c;
                if (in_ready) ir_bad = 1;
            end
            if (out_valid && out_ready) begin
                got[n] = ser_out;
                n++;
            end
        end
        out_ready = 1'b1;
        check("bits_received", n, 4);
        check("first_bit_latency", first, 0);
        check("in_ready_low_in_send", int'(ir_bad), 0);
    endtask

    typedef struct {
        logic [3:0] op;
        bit         gap;
        int         clr_idx;
        logic [3:0] exp_reg;
        logic [3:0] exp_sum;
    } vec_t;

    vec_t vecs[5];
    logic [3:0] got;
    int x0;

    initial begin
        vecs[0] = '{4'd3,  1'b0, -1, 4'd0, 4'd3};
        vecs[1] = '{4'd6,  1'b0, -1, 4'd3, 4'd9};
        vecs[2] = '{4'd10, 1'b0, -1, 4'd9, 4'd3};
        vecs[3] = '{4'd13, 1'b1,  1, 4'd0, 4'd13};
        vecs[4] = '{4'd7,  1'b0,  3, 4'd0, 4'd7};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_ser_out", int'(ser_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sipo", int'(sipo_input), 0);
        check("rst_reg", int'(register_input), 0);

        foreach (vecs[i]) begin
            collect(vecs[i].op, vecs[i].gap, vecs[i].clr_idx);
            check("add_busy", int'(busy), 1);
            check("add_in_ready", int'(in_ready), 0);
            check("add_sipo", int'(sipo_input), int'(vecs[i].op));
            check("add_reg", int'(register_input), int'(vecs[i].exp_reg));
            recv(vecs[i].exp_sum, -1, 0, got);
            check("result", int'(got), int'(vecs[i].exp_sum));
            @(negedge clk);
            check("done_in_ready", int'(in_ready), 1);
            check("done_out_valid", int'(out_valid), 0);
            check("done_acc", int'(register_input), int'(vecs[i].exp_sum));
        end

        // Backpressure: acc 7 + 4 = 11, bits 1,1,0,1; stall on bit 1
        collect(4'd4, 1'b0, -1);
        x0 = xfers;
        recv(4'd11, 1, 3, got);
        check("bp_result", int'(got), 11);
        @(negedge clk);
        check("bp_transfers", xfers - x0, 4);
        check("bp_in_ready", int'(in_ready), 1);

        // Reset in the middle of SEND after two transfers
        collect(4'd6, 1'b0, -1);
        repeat (3) @(negedge clk);
        check("mid_send_valid", int'(out_valid), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_out_valid", int'(out_valid), 0);
        check("mrst_in_ready", int'(in_ready), 1);
        check("mrst_reg", int'(register_input), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_ser_out", int'(ser_out), 0);
        collect(4'd5, 1'b0, -1);
        check("mrst_add_reg", int'(register_input), 0);
        recv(4'd5, -1, 0, got);
        check("mrst_result", int'(got), 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
